// File: rtl/sprite_opacity_reader_pkg.sv
// sprite_opacity_reader_pkg: shared sprite geometry, SRAM widths, bitmap bases and FSM state type
package sprite_opacity_reader_pkg;
  localparam int IMAGE_SIZE = 32;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;
  localparam int READ_LAT = 2;
  localparam logic [ADDR_W-1:0] CAR1_BASE = 20'h00000;
  localparam logic [ADDR_W-1:0] CAR2_BASE = 20'h00040;
  localparam int WPR = IMAGE_SIZE / DATA_W;
  localparam int ROW_W = $clog2(IMAGE_SIZE);
  localparam int WORD_W = WPR > 1 ? $clog2(WPR) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT} state_t;
endpackage

// File: rtl/sram_read_pipe.sv
// sram_read_pipe: fixed-latency valid/tag shift register tracking in-flight SRAM reads
module sram_read_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_pending
);
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH*TAG_W-1:0] tag_q, tag_d;
  // newest entry enters at the top stage, stage 0 is the one being sampled
  always_comb begin
    valid_d = i_flush ? '0 : (valid_q >> 1) | (DEPTH'(i_valid) << (DEPTH - 1));
    tag_d = i_flush ? '0 : (tag_q >> TAG_W) | ((DEPTH*TAG_W)'(i_tag) << ((DEPTH - 1) * TAG_W));
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      tag_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q <= tag_d;
    end
  end
  assign o_valid = valid_q[0];
  assign o_tag = tag_q[TAG_W-1:0];
  assign o_pending = |(valid_q >> 1);
endmodule

// File: rtl/sprite_opacity_reader.sv
// sprite_opacity_reader: fetches a car opacity bitmap from SRAM and presents it row by row
module sprite_opacity_reader
  import sprite_opacity_reader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_car_sel,
  input  logic                  i_abort,
  input  logic                  i_grant,
  output logic [ADDR_W-1:0]     o_sram_addr,
  output logic                  o_sram_rd,
  input  logic [DATA_W-1:0]     i_sram_data,
  output logic [IMAGE_SIZE-1:0] o_row_data,
  output logic [ROW_W-1:0]      o_row_idx,
  output logic                  o_row_valid,
  input  logic                  i_row_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic sel_q, sel_d, done_q, done_d;
  logic [IMAGE_SIZE-1:0] data_q, data_d;
  logic rd, abort, p_valid, p_pending;
  logic [WORD_W-1:0] p_tag;
  logic [ADDR_W-1:0] addr;
  assign abort = i_abort && state_q != S_IDLE;
  assign rd = state_q == S_ISSUE && i_grant && !i_abort;
  assign addr = (sel_q ? CAR2_BASE : CAR1_BASE) + ADDR_W'(row_q) * ADDR_W'(WPR) + ADDR_W'(word_q);
  sram_read_pipe #(.DEPTH(READ_LAT), .TAG_W(WORD_W)) u_pipe (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_flush(abort),
    .i_valid(rd),
    .i_tag(word_q),
    .o_valid(p_valid),
    .o_tag(p_tag),
    .o_pending(p_pending)
  );
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    word_d = word_q;
    sel_d = sel_q;
    done_d = 1'b0;
    data_d = p_valid ? (data_q & ~(IMAGE_SIZE'({DATA_W{1'b1}}) << (int'(p_tag) * DATA_W)))
                       | (IMAGE_SIZE'(i_sram_data) << (int'(p_tag) * DATA_W)) : data_q;
    if (abort) begin
      state_d = S_IDLE;
      row_d = '0;
      word_d = '0;
      data_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (i_start && !i_abort) begin
          state_d = S_ISSUE;
          sel_d = i_car_sel;
          row_d = '0;
          word_d = '0;
        end
        S_ISSUE: if (rd) begin
          state_d = word_q == WORD_W'(WPR - 1) ? S_WAIT : S_ISSUE;
          word_d = word_q == WORD_W'(WPR - 1) ? word_q : word_q + 1'b1;
        end
        S_WAIT: state_d = p_pending ? S_WAIT : S_PRESENT;
        S_PRESENT: if (i_row_ready) begin
          if (row_q == ROW_W'(IMAGE_SIZE - 1)) begin
            state_d = S_IDLE;
            done_d = 1'b1;
            row_d = '0;
          end else begin
            state_d = S_ISSUE;
            row_d = row_q + 1'b1;
            word_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      row_q <= '0;
      word_q <= '0;
      sel_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      word_q <= word_d;
      sel_q <= sel_d;
      done_q <= done_d;
      data_q <= data_d;
    end
  end
  assign o_sram_rd = rd;
  assign o_sram_addr = rd ? addr : '0;
  assign o_row_data = data_q;
  assign o_row_idx = row_q;
  assign o_row_valid = state_q == S_PRESENT;
  assign o_busy = state_q != S_IDLE;
  assign o_done = done_q;
endmodule
